mdu_hilo: RTL

- Multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.
- Consumes the forwarded GRF operands (rs/rt read data) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds HI/LO, which feed the MFHI/MFLO result path back to GRF writeback.
- Exposes a busy flag so the hazard unit can stall ID while an operation is in flight.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_arith.sv | 81 ++++++++
 rtl/mdu_hilo.sv | 115 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encoding and default busy-cycle counts. Also imported by the
// decoder and hazard unit so all three agree on the op field.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the MDU.
//   op            : operation code (mdu_pkg encodings)
//   a, b          : rs / rt operands
//   cur_hi/cur_lo : current architectural HI/LO
//   res_hi/res_lo : HI/LO value the operation would produce
// Ops other than MULT/MULTU/DIV/DIVU, and any divide by zero, return
// cur_hi/cur_lo so the caller can commit unconditionally.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] sdiv_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] mq;
  logic [31:0] mr;

  always_comb begin
    // Sign-extended 64x64 product; the low 64 bits equal the signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Divisor forced non-zero so the dividers never see zero; the result
    // is discarded in that case anyway.
    div_b  = (b == '0) ? 32'd1 : b;
    uq     = a / div_b;
    ur     = a % div_b;

    // Signed divide on magnitudes. 0x80000000 keeps its bit pattern as a
    // magnitude, which yields the required 0x80000000 / -1 result.
    abs_a  = a[31] ? (~a + 32'd1) : a;
    abs_b  = b[31] ? (~b + 32'd1) : b;
    sdiv_b = (abs_b == '0) ? 32'd1 : abs_b;
    mq     = abs_a / sdiv_b;
    mr     = abs_a % sdiv_b;
    sq     = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
    sr     = a[31] ? (~mr + 32'd1) : mr;

    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        if (b != '0) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MDU_DIVU: begin
        if (b != '0) begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers (EX stage).
//   clk, reset : clock, asynchronous active-high reset
//   start, op  : operation valid + code, sampled on the rising edge
//   a, b       : forwarded rs / rt values
//   hi, lo     : architectural HI/LO registers
//   busy       : high while a mult/div is in flight
// Results are computed and latched at the start edge, then held for
// N busy cycles before being committed to HI/LO.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // New requests are ignored here; the hazard unit stalls them.
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_RUN);

endmodule
